rf_wb_scheduler: RTL and testbench

Writeback scheduler and scoreboard for the 32 x 32-bit integer register file. Two writeback requesters share the register file's single write port: the ALU/execute path (EX) and the load path (LD). Round-robin arbitration decides which one writes each cycle. A per-register busy scoreboard lets the issue stage detect RAW and WAW hazards. The block sits between the EX/LD result paths and the register file's write port, and beside the issue stage's read-port addresses.

---
 rtl/rf_wb_scheduler.sv | 143 ++++++++++++++
 tb/tb_rf_wb_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_wb_scheduler                                                          |
// | Round-robin EX/LD writeback arbiter plus busy scoreboard for the integer |
// | register file. Optional feature macro: RF_WB_SCHEDULER_BYPASS_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rf_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rs1_fwd_valid,
  output logic            rs2_fwd_valid,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic [XLEN-1:0] rs2_fwd_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy_vec
);

  localparam logic [4:0] c_X0 = 5'd0;

  logic [NREG-1:1] r_busy;
  logic [NREG-1:1] w_busy_nxt;
  logic [NREG-1:0] w_busy_all;
  logic            r_pri;
  logic            r_we;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;

  logic            w_grant_any;
  logic [4:0]      w_grant_rd;
  logic [XLEN-1:0] w_grant_data;
  logic            w_set;
  logic            w_rs1_hit;
  logic            w_rs2_hit;

  assign w_busy_all = {r_busy, 1'b0};
  assign busy_vec   = w_busy_all;

  // x0 reads as never busy, so an issue to x0 is always accepted.
  assign iss_ready = ~w_busy_all[iss_rd];
  assign w_set     = iss_valid && iss_ready && (iss_rd != c_X0);

  // Grant depends only on the two valids and the round-robin pointer.
  assign ex_ready = ex_valid && (!ld_valid || !r_pri);
  assign ld_ready = ld_valid && (!ex_valid ||  r_pri);

  assign w_grant_any  = ex_ready || ld_ready;
  assign w_grant_rd   = ld_ready ? ld_rd   : ex_rd;
  assign w_grant_data = ld_ready ? ld_data : ex_data;

  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < NREG; r++) begin
      if (r_we && (r_waddr == 5'(r))) begin
        w_busy_nxt[r] = 1'b0;
      end
      if (w_set && (iss_rd == 5'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Pointer always moves to whoever did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pri <= 1'b0;
    end else if (ex_valid && ld_valid) begin
      r_pri <= ~r_pri;
    end else if (ex_valid) begin
      r_pri <= 1'b1;
    end else if (ld_valid) begin
      r_pri <= 1'b0;
    end
  end

  // A granted x0 writeback is consumed without touching the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_grant_any && (w_grant_rd != c_X0);
      if (w_grant_any && (w_grant_rd != c_X0)) begin
        r_waddr <= w_grant_rd;
        r_wdata <= w_grant_data;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

`ifdef RF_WB_SCHEDULER_BYPASS_EN
  assign w_rs1_hit     = r_we && (r_waddr != c_X0) && (rs1_addr == r_waddr);
  assign w_rs2_hit     = r_we && (r_waddr != c_X0) && (rs2_addr == r_waddr);
  assign rs1_fwd_valid = w_rs1_hit;
  assign rs2_fwd_valid = w_rs2_hit;
  assign rs1_fwd_data  = w_rs1_hit ? r_wdata : '0;
  assign rs2_fwd_data  = w_rs2_hit ? r_wdata : '0;
`else
  assign w_rs1_hit     = 1'b0;
  assign w_rs2_hit     = 1'b0;
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
`endif

  assign rs1_busy = w_busy_all[rs1_addr] && !w_rs1_hit;
  assign rs2_busy = w_busy_all[rs2_addr] && !w_rs2_hit;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rf_wb_scheduler                                                       |
// | Directed table-driven bench for rf_wb_scheduler.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rf_wb_scheduler;

`ifdef RF_WB_SCHEDULER_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;

  int n_cmp = 0;
  int n_err = 0;

  rf_wb_scheduler #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  typedef struct packed {
    logic        iv;   logic [4:0] ird;
    logic        exv;  logic [4:0] exrd; logic [31:0] exd;
    logic        ldv;  logic [4:0] ldrd; logic [31:0] ldd;
    logic [4:0]  a1;   logic [4:0] a2;
    logic        e_iss; logic e_ex; logic e_ld; logic e_we; logic chkw;
    logic [4:0]  e_wa; logic [31:0] e_wd; logic [31:0] e_busy;
    logic        e_b1; logic e_b2;
    logic        e_f1v; logic [31:0] e_f1d;
    logic        e_f2v; logic [31:0] e_f2d;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic iv, input logic [4:0] ird,
    input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
    input logic ldv, input logic [4:0] ldrd, input logic [31:0] ldd,
    input logic [4:0] a1, input logic [4:0] a2,
    input logic e_iss, input logic e_ex, input logic e_ld, input logic e_we, input logic chkw,
    input logic [4:0] e_wa, input logic [31:0] e_wd, input logic [31:0] e_busy,
    input logic e_b1, input logic e_b2,
    input logic e_f1v, input logic [31:0] e_f1d,
    input logic e_f2v, input logic [31:0] e_f2d);
    vec_t v;
    v.iv = iv; v.ird = ird; v.exv = exv; v.exrd = exrd; v.exd = exd;
    v.ldv = ldv; v.ldrd = ldrd; v.ldd = ldd; v.a1 = a1; v.a2 = a2;
    v.e_iss = e_iss; v.e_ex = e_ex; v.e_ld = e_ld; v.e_we = e_we; v.chkw = chkw;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_busy = e_busy;
    v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_f1v = e_f1v; v.e_f1d = e_f1d; v.e_f2v = e_f2v; v.e_f2d = e_f2d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rd = 0;
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    rs1_addr = 0; rs2_addr = 0;
  endtask

  initial begin
    logic [31:0] ex_d, ld_d, last_d;
    logic [4:0]  last_a;

    // iss, ex, ld, rs addrs | iss_rdy ex_rdy ld_rdy we chkw waddr wdata busy | b1 b2 | fwd1 | fwd2
    tbl[0]  = mk(0,0, 0,0,0, 0,0,0, 0,0,  1,0,0,0,1, 0,0,0,  0,0, 0,0, 0,0);
    tbl[1]  = mk(1,5, 0,0,0, 0,0,0, 0,0,  1,0,0,0,1, 0,0,0,  0,0, 0,0, 0,0);
    tbl[2]  = mk(0,0, 1,5,32'hDEADBEEF, 0,0,0, 5,0,  1,1,0,0,1, 0,0,32'h20,  1,0, 0,0, 0,0);
    tbl[3]  = mk(0,0, 0,0,0, 0,0,0, 5,0,  1,0,0,1,1, 5,32'hDEADBEEF,32'h20,
                 !BYP,0, BYP,(BYP ? 32'hDEADBEEF : 32'h0), 0,0);
    tbl[4]  = mk(0,0, 0,0,0, 0,0,0, 5,0,  1,0,0,0,1, 5,32'hDEADBEEF,0,  0,0, 0,0, 0,0);
    tbl[5]  = mk(0,0, 1,3,32'h11, 1,4,32'h22, 0,0,  1,0,1,0,1, 5,32'hDEADBEEF,0, 0,0, 0,0, 0,0);
    tbl[6]  = mk(0,0, 1,3,32'h11, 1,6,32'h33, 0,0,  1,1,0,1,1, 4,32'h22,0, 0,0, 0,0, 0,0);
    tbl[7]  = mk(0,0, 1,8,32'h44, 1,6,32'h33, 0,0,  1,0,1,1,1, 3,32'h11,0, 0,0, 0,0, 0,0);
    tbl[8]  = mk(0,0, 1,8,32'h44, 0,0,0, 0,0,  1,1,0,1,1, 6,32'h33,0, 0,0, 0,0, 0,0);
    tbl[9]  = mk(0,0, 0,0,0, 0,0,0, 0,0,  1,0,0,1,1, 8,32'h44,0, 0,0, 0,0, 0,0);
    tbl[10] = mk(1,7, 0,0,0, 0,0,0, 0,0,  1,0,0,0,1, 8,32'h44,0, 0,0, 0,0, 0,0);
    tbl[11] = mk(1,7, 0,0,0, 1,7,32'h77, 0,0,  0,0,1,0,1, 8,32'h44,32'h80, 0,0, 0,0, 0,0);
    tbl[12] = mk(1,7, 0,0,0, 0,0,0, 0,0,  0,0,0,1,1, 7,32'h77,32'h80, 0,0, 0,0, 0,0);
    tbl[13] = mk(1,7, 0,0,0, 0,0,0, 0,0,  1,0,0,0,1, 7,32'h77,0, 0,0, 0,0, 0,0);
    tbl[14] = mk(1,0, 0,0,0, 0,0,0, 0,0,  1,0,0,0,1, 7,32'h77,32'h80, 0,0, 0,0, 0,0);
    tbl[15] = mk(0,0, 0,0,0, 1,0,32'hFFFF, 0,0,  1,0,1,0,1, 7,32'h77,32'h80, 0,0, 0,0, 0,0);
    tbl[16] = mk(0,0, 0,0,0, 0,0,0, 0,0,  1,0,0,0,0, 0,0,32'h80, 0,0, 0,0, 0,0);
    tbl[17] = mk(1,9, 0,0,0, 0,0,0, 0,0,  1,0,0,0,0, 0,0,32'h80, 0,0, 0,0, 0,0);
    tbl[18] = mk(0,0, 1,9,32'h1234, 0,0,0, 0,9,  1,1,0,0,0, 0,0,32'h280, 0,1, 0,0, 0,0);
    tbl[19] = mk(0,0, 0,0,0, 0,0,0, 7,9,  1,0,0,1,1, 9,32'h1234,32'h280,
                 1,!BYP, 0,0, BYP,(BYP ? 32'h1234 : 32'h0));
    tbl[20] = mk(0,0, 0,0,0, 0,0,0, 0,9,  1,0,0,0,1, 9,32'h1234,32'h80, 0,0, 0,0, 0,0);

    // Reset values, with readies checked combinationally while held in reset.
    rst_n = 0;
    idle_inputs();
    iss_rd = 3; ex_valid = 1; ld_valid = 1;
    #12;
    chk("rst rf_we", 32'(rf_we), 0);
    chk("rst rf_waddr", 32'(rf_waddr), 0);
    chk("rst rf_wdata", rf_wdata, 0);
    chk("rst busy_vec", busy_vec, 0);
    chk("rst fwd", {30'd0, rs1_fwd_valid, rs2_fwd_valid}, 0);
    chk("rst fwd_data", rs1_fwd_data | rs2_fwd_data, 0);
    chk("rst iss_ready", 32'(iss_ready), 1);
    chk("rst ex_ready", 32'(ex_ready), 1);
    chk("rst ld_ready", 32'(ld_ready), 0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;

    for (int i = 0; i < NV; i++) begin
      iss_valid = tbl[i].iv;  iss_rd = tbl[i].ird;
      ex_valid  = tbl[i].exv; ex_rd  = tbl[i].exrd; ex_data = tbl[i].exd;
      ld_valid  = tbl[i].ldv; ld_rd  = tbl[i].ldrd; ld_data = tbl[i].ldd;
      rs1_addr  = tbl[i].a1;  rs2_addr = tbl[i].a2;
      @(negedge clk);
      chk($sformatf("v%0d iss_ready", i), 32'(iss_ready), 32'(tbl[i].e_iss));
      chk($sformatf("v%0d ex_ready", i),  32'(ex_ready),  32'(tbl[i].e_ex));
      chk($sformatf("v%0d ld_ready", i),  32'(ld_ready),  32'(tbl[i].e_ld));
      chk($sformatf("v%0d rf_we", i),     32'(rf_we),     32'(tbl[i].e_we));
      if (tbl[i].chkw) begin
        chk($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_wa));
        chk($sformatf("v%0d rf_wdata", i), rf_wdata, tbl[i].e_wd);
      end
      chk($sformatf("v%0d busy_vec", i), busy_vec, tbl[i].e_busy);
      chk($sformatf("v%0d rs1_busy", i), 32'(rs1_busy), 32'(tbl[i].e_b1));
      chk($sformatf("v%0d rs2_busy", i), 32'(rs2_busy), 32'(tbl[i].e_b2));
      chk($sformatf("v%0d rs1_fwd_valid", i), 32'(rs1_fwd_valid), 32'(tbl[i].e_f1v));
      chk($sformatf("v%0d rs1_fwd_data", i), rs1_fwd_data, tbl[i].e_f1d);
      chk($sformatf("v%0d rs2_fwd_valid", i), 32'(rs2_fwd_valid), 32'(tbl[i].e_f2v));
      chk($sformatf("v%0d rs2_fwd_data", i), rs2_fwd_data, tbl[i].e_f2d);
      @(posedge clk); #1;
    end

    // Contention from reset: EX first, then strict alternation.
    idle_inputs();
    rst_n = 0;
    ex_d = 32'h11; ld_d = 32'h22;
    ex_valid = 1; ex_rd = 3; ex_data = ex_d;
    ld_valid = 1; ld_rd = 4; ld_data = ld_d;
    last_a = 0; last_d = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("cont%0d rf_we", i), 32'(rf_we), 1);
        chk($sformatf("cont%0d rf_waddr", i), 32'(rf_waddr), 32'(last_a));
        chk($sformatf("cont%0d rf_wdata", i), rf_wdata, last_d);
      end
      if (i < 4) begin
        chk($sformatf("cont%0d ex_ready", i), 32'(ex_ready), (i % 2 == 0) ? 1 : 0);
        chk($sformatf("cont%0d ld_ready", i), 32'(ld_ready), (i % 2 == 1) ? 1 : 0);
        last_a = (i % 2 == 0) ? 5'd3 : 5'd4;
        last_d = (i % 2 == 0) ? ex_d : ld_d;
      end
      @(posedge clk); #1;
      if (i % 2 == 0) begin ex_d = ex_d + 32'h100; ex_data = ex_d; end
      else            begin ld_d = ld_d + 32'h100; ld_data = ld_d; end
      if (i == 3) begin ex_valid = 0; ld_valid = 0; end
    end

    // Mid-operation reset with a write in flight and x5/x7 busy.
    idle_inputs();
    iss_valid = 1; iss_rd = 5;
    @(posedge clk); #1;
    iss_rd = 7;
    ex_valid = 1; ex_rd = 2; ex_data = 32'hAB;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("midrst pre rf_we", 32'(rf_we), 1);
    chk("midrst pre busy_vec", busy_vec, 32'h0000_00A0);
    rst_n = 0;
    #1;
    chk("midrst rf_we", 32'(rf_we), 0);
    chk("midrst busy_vec", busy_vec, 0);
    chk("midrst rf_waddr", 32'(rf_waddr), 0);
    chk("midrst rf_wdata", rf_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d rf_we", i), 32'(rf_we), 0);
      chk($sformatf("postrst%0d busy_vec", i), busy_vec, 0);
      @(posedge clk); #1;
    end
    ex_valid = 1; ld_valid = 1; ex_rd = 1; ld_rd = 2;
    #1;
    chk("postrst pri ex_ready", 32'(ex_ready), 1);
    chk("postrst pri ld_ready", 32'(ld_ready), 0);
    idle_inputs();
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
